// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding one shared serial pattern matcher.
// Each granted word is shifted MSB-first through an overlapping Mealy matcher.
module seq_scan_arbiter #(
    parameter int               NREQ    = 4,
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORD_W-1:0]   data_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     x_out,
    output logic                     z_out,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int ID_W = $clog2(NREQ);
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] BIT_MIN  = BC_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [WORD_W-1:0]   shift_q,     shift_d;
    logic [PAT_W-2:0]    hist_q,      hist_d;
    logic [BC_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [NREQ-1:0]     gnt_q,       gnt_d;
    logic [ID_W-1:0]     ptr_q,       ptr_d;
    logic                z_q,         z_d;
    logic [ID_W-1:0]     done_id_q,   done_id_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;

    logic [ID_W-1:0]     winner;
    logic                winner_found;
    logic                x_bit;
    logic                match_hit;
    logic [CNT_W-1:0]    cnt_inc;

    // Search upward from the last granted requester, wrapping around.
    always_comb begin
        winner       = ptr_q;
        winner_found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!winner_found && req[ID_W'((int'(ptr_q) + off) % NREQ)]) begin
                winner_found = 1'b1;
                winner       = ID_W'((int'(ptr_q) + off) % NREQ);
            end
        end
    end

    assign x_bit     = (state_q == SHIFT) ? shift_q[WORD_W-1] : 1'b0;
    assign match_hit = (state_q == SHIFT) && ({hist_q, x_bit} == PATTERN)
                       && (bit_cnt_q >= BIT_MIN);
    assign cnt_inc   = (match_hit && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hist_d      = hist_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        ptr_d       = ptr_q;
        z_d         = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    shift_d   = data_in[int'(winner)*WORD_W +: WORD_W];
                    hist_d    = '0;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    gnt_d     = NREQ'(1) << winner;
                    ptr_d     = winner;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                hist_d    = {hist_q, x_bit};
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                z_d       = match_hit;
                cnt_d     = cnt_inc;
                // The final count must include a match formed by the last bit.
                if (bit_cnt_q == BIT_LAST) begin
                    match_cnt_d = cnt_inc;
                    done_id_d   = ptr_q;
                    state_d     = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hist_q      <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            ptr_q       <= ID_W'(NREQ - 1);
            z_q         <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hist_q      <= hist_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            z_q         <= z_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign x_out     = x_bit;
    assign z_out     = z_q;
    assign done      = (state_q == REPORT);
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter: word-level reference model checked every cycle,
// plus directed scans with hand-computed results.
module tb_seq_scan_arbiter;

    localparam int NREQ   = 4;
    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 4;
    localparam logic [PAT_W-1:0] PAT = 4'b1001;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*WORD_W-1:0] data_in = '0;

    logic [NREQ-1:0]  gnt, gnt_s;
    logic             busy, busy_s, x_out, x_out_s, z_out, z_out_s, done, done_s;
    logic [1:0]       done_id, done_id_s;
    logic [CNT_W-1:0] match_cnt;
    logic [0:0]       match_cnt_s;

    int tests = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    seq_scan_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W),
                       .PATTERN(PAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .gnt(gnt), .busy(busy), .x_out(x_out), .z_out(z_out),
        .done(done), .done_id(done_id), .match_cnt(match_cnt));

    seq_scan_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W),
                       .PATTERN(PAT), .CNT_W(1)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .gnt(gnt_s), .busy(busy_s), .x_out(x_out_s), .z_out(z_out_s),
        .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s));

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // True when the last PAT_W of the first j received bits equal the pattern.
    function automatic bit match_at(input logic [WORD_W-1:0] w, input int j);
        logic [WORD_W-1:0] s;
        if (j < PAT_W || j > WORD_W) return 1'b0;
        s = w >> (WORD_W - j);
        return s[PAT_W-1:0] == PAT;
    endfunction

    function automatic int count_matches(input logic [WORD_W-1:0] w);
        int c = 0;
        for (int j = 1; j <= WORD_W; j++) if (match_at(w, j)) c++;
        return c;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: phase 0 = idle, 1..WORD_W = bit cycles, WORD_W+1 = report.
    int m_phase = 0, m_ptr = NREQ - 1, m_id = 0, m_found = 0;
    int m_cnt_hold = 0, m_sat_hold = 0, m_id_hold = 0, m_try = 0;
    logic [WORD_W-1:0] m_word = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0; m_ptr = NREQ - 1;
            m_cnt_hold = 0; m_sat_hold = 0; m_id_hold = 0;
        end else if (m_phase == 0) begin
            m_found = 0;
            for (int off = 1; off <= NREQ; off++) begin
                m_try = (m_ptr + off) % NREQ;
                if (!m_found && req[m_try]) begin
                    m_found = 1;
                    m_id = m_try;
                end
            end
            if (m_found != 0) begin
                m_word  = data_in[m_id*WORD_W +: WORD_W];
                m_ptr   = m_id;
                m_phase = 1;
            end
        end else if (m_phase <= WORD_W) begin
            m_phase++;
            if (m_phase == WORD_W + 1) begin
                m_cnt_hold = min_int(count_matches(m_word), (1 << CNT_W) - 1);
                m_sat_hold = min_int(count_matches(m_word), 1);
                m_id_hold  = m_id;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("gnt", int'(gnt), (m_phase == 1) ? (1 << m_id) : 0);
            check_output("busy", int'(busy), int'(m_phase != 0));
            check_output("x_out", int'(x_out),
                         (m_phase >= 1 && m_phase <= WORD_W) ? int'(m_word[WORD_W-m_phase]) : 0);
            check_output("z_out", int'(z_out),
                         (m_phase >= 2) ? int'(match_at(m_word, m_phase - 1)) : 0);
            check_output("done", int'(done), int'(m_phase == WORD_W + 1));
            check_output("done_id", int'(done_id), m_id_hold);
            check_output("match_cnt", int'(match_cnt), m_cnt_hold);
            check_output("match_cnt_sat", int'(match_cnt_s), m_sat_hold);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits (bounded) for any grant; returns index or -1 on timeout.
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 30 && idx < 0; k++) begin
            @(negedge clk);
            if (gnt != '0) idx = oh2idx(gnt);
        end
        if (idx < 0) check_output("grant_timeout", 0, 1);
    endtask

    // One scan on requester id; collects x bits, z cycle mask and report fields.
    task automatic apply_stimulus(input int id, input logic [WORD_W-1:0] w,
                                  output int got_id, output int got_cnt, output int got_sat,
                                  output int z_mask, output logic [WORD_W-1:0] xs);
        int g;
        bit seen;
        got_id = -1; got_cnt = -1; got_sat = -1; z_mask = 0; xs = '0;
        data_in[id*WORD_W +: WORD_W] = w;
        req = NREQ'(1) << id;
        wait_grant(g);
        req = '0;
        if (g < 0) return;
        check_output("grant_index", g, id);
        xs[WORD_W-1] = x_out;
        seen = 1'b0;
        for (int cyc = 2; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            if (z_out) z_mask |= (1 << cyc);
            if (cyc <= WORD_W) xs[WORD_W-cyc] = x_out;
            if (done) begin
                seen = 1'b1;
                check_output("done_cycle", cyc, WORD_W + 1);
                got_id = int'(done_id); got_cnt = int'(match_cnt); got_sat = int'(match_cnt_s);
            end
        end
        if (!seen) check_output("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int id, cnt, sat, zm, g;
        logic [WORD_W-1:0] xs;
        int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 3, 1};

        apply_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_match_cnt", int'(match_cnt), 0);

        apply_stimulus(0, 8'h99, id, cnt, sat, zm, xs);
        check_output("t1_x_seq", int'(xs), 8'h99);
        check_output("t1_z_cycles", zm, (1 << 5) | (1 << 9));
        check_output("t1_done_id", id, 0);
        check_output("t1_match_cnt", cnt, 2);
        check_output("t6_sat_cnt", sat, 1);

        apply_stimulus(2, 8'h92, id, cnt, sat, zm, xs);
        check_output("t2_z_cycles", zm, (1 << 5) | (1 << 8));
        check_output("t2_done_id", id, 2);
        check_output("t2_match_cnt", cnt, 2);
        apply_stimulus(1, 8'h00, id, cnt, sat, zm, xs);
        check_output("t2_zero_cnt", cnt, 0);
        check_output("t2_zero_z", zm, 0);
        apply_stimulus(3, 8'hFF, id, cnt, sat, zm, xs);
        check_output("t2_ones_cnt", cnt, 0);
        check_output("t2_ones_z", zm, 0);

        apply_stimulus(0, 8'h09, id, cnt, sat, zm, xs);
        check_output("t4_first_cnt", cnt, 1);
        apply_stimulus(0, 8'h10, id, cnt, sat, zm, xs);
        check_output("t4_second_cnt", cnt, 0);
        check_output("t4_second_z", zm, 0);

        apply_reset();
        data_in = {8'h44, 8'h33, 8'h92, 8'h99};
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            if (n == 6) req = 4'b1010;
            wait_grant(g);
            check_output("t3_rr_grant", g, rr_exp[n]);
            if (g < 0) break;
        end
        req = '0;
        repeat (12) @(negedge clk);

        apply_stimulus(0, 8'h99, id, cnt, sat, zm, xs);
        data_in[WORD_W-1:0] = 8'h99;
        req = 4'b0001;
        wait_grant(g);
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("t5_busy", int'(busy), 0);
        check_output("t5_done", int'(done), 0);
        check_output("t5_match_cnt", int'(match_cnt), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("t5_no_done", int'(done), 0);
        req = 4'b0011;
        wait_grant(g);
        check_output("t5_first_grant", g, 0);
        req = 4'b0010;
        wait_grant(g);
        check_output("t5_second_grant", g, 1);
        req = '0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
